rca_adder: RTL and testbench

- Parameterised N-bit ripple-carry adder with registered outputs.
- Computes {Cout,S} = A + B + Cin and exports the per-bit propagate vector P = A ^ B.
- Datapath is a structural chain of N 1-bit full-adder cells; the carry ripples from bit 0 to bit N-1.
- Used as the baseline adder in the adder-comparison datapath; results are captured in output registers clocked by clk.

---
 rtl/rca_adder.sv | 70 +++++++
 tb/tb_rca_adder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rca_adder.sv
// N-bit ripple-carry adder with a registered output stage.
// Computes {Cout,S} = A + B + Cin through a chain of 1-bit full-adder
// cells and also exports the per-bit propagate vector P = A ^ B.

// One full-adder cell: propagate, sum and carry-out for a single bit.
module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic p,
    output logic s,
    output logic co
);

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

module rca_adder #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic [N-1:0] P
);

    // c[i] is the carry into bit i; c[N] is the carry out of the top bit.
    logic [N:0]   c;
    logic [N-1:0] s_next;
    logic [N-1:0] p_next;

    assign c[0] = Cin;

    // Structural ripple chain: the carry path runs through every cell in
    // turn, so the clock period must cover N full-adder delays.
    for (genvar i = 0; i < N; i++) begin : g_cell
        rca_fa_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .p  (p_next[i]),
            .s  (s_next[i]),
            .co (c[i+1])
        );
    end

    // Output registers: capture the settled ripple result each cycle so
    // that internal carry glitches never reach the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            Cout <= 1'b0;
            P    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, so ordering inside this block cannot matter.
            S    <= s_next;
            Cout <= c[N];
            P    <= p_next;
        end
    end

endmodule

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder (N = 16): directed corner cases,
// asynchronous reset behaviour and a long random back-to-back regression
// compared against a plain-arithmetic reference model.
module tb_rca_adder;

    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic [N-1:0] S;
    logic         Cout;
    logic [N-1:0] P;

    int checks   = 0;
    int failures = 0;

    rca_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .S     (S),
        .Cout  (Cout),
        .P     (P)
    );

    // 10-unit clock: rising edges at 5, 15, 25 ...; checks happen on falling edges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value is wrong.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        A   = a;
        B   = b;
        Cin = ci;
    endtask

    // Reference model: the registered outputs must equal the full-width
    // integer sum and the bitwise XOR of the operands applied a cycle ago.
    task automatic expect_result(input string tag, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic ci);
        int unsigned total;
        total = int'(a) + int'(b) + int'(ci);
        check({tag, "_sum"}, 32'({Cout, S}), total);
        check({tag, "_p"}, 32'(P), 32'(a ^ b));
    endtask

    task automatic expect_zero(input string tag);
        check({tag, "_sum"}, 32'({Cout, S}), 32'd0);
        check({tag, "_p"}, 32'(P), 32'd0);
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic         rc;

        rst_n = 1'b0;
        apply(16'hFFFF, 16'hFFFF, 1'b1);

        // Reset held across several rising edges with maximal operands.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_zero("rst_hold");
        end

        // First edge after release captures the operands present at that edge.
        rst_n = 1'b1;
        @(negedge clk);
        expect_result("rst_release", 16'hFFFF, 16'hFFFF, 1'b1);

        // Mid-cycle reset clears outputs immediately, before any clock edge.
        #2 rst_n = 1'b0;
        #1 expect_zero("rst_async");
        @(negedge clk);
        expect_zero("rst_async_hold");

        // In-flight result is discarded; new operands at the first post-release edge.
        rst_n = 1'b1;
        apply(16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        expect_result("no_carry", 16'h1234, 16'h4321, 1'b0);

        // Directed corner vectors, one cycle each.
        apply(16'hFFFF, 16'h0000, 1'b1);
        @(negedge clk);
        expect_result("full_ripple", 16'hFFFF, 16'h0000, 1'b1);
        check("full_ripple_s", 32'(S), 32'h0000);
        check("full_ripple_cout", 32'(Cout), 32'd1);

        apply(16'h8000, 16'h8000, 1'b1);
        @(negedge clk);
        expect_result("msb_generate", 16'h8000, 16'h8000, 1'b1);

        apply(16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        expect_result("max_result", 16'hFFFF, 16'hFFFF, 1'b1);
        check("max_result_lit", 32'({Cout, S}), 32'h1FFFF);

        apply(16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        expect_zero("all_zero");

        // Back-to-back operands on consecutive edges.
        apply(16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        expect_result("b2b_first", 16'hFFFF, 16'h0001, 1'b0);
        check("b2b_first_p", 32'(P), 32'hFFFE);
        apply(16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        expect_result("b2b_second", 16'h0001, 16'h0001, 1'b0);
        check("b2b_second_lit", 32'({Cout, S}), 32'h00002);

        // Random regression: a new vector every cycle, each checked one cycle later.
        void'($urandom(42));
        ra = N'($urandom);
        rb = N'($urandom);
        rc = 1'($urandom);
        apply(ra, rb, rc);
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            expect_result("random", ra, rb, rc);
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            apply(ra, rb, rc);
        end
        @(negedge clk);
        expect_result("random_last", ra, rb, rc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
